// File: rtl/floo_wormhole_arbiter_if.sv
// Handshake bundle between the per-input route selectors (master side) and one
// output-port wormhole arbiter (slave side).
interface floo_wormhole_arbiter_if #(
    parameter int  NumInputs = 5,
    parameter type flit_t    = struct packed {
        struct packed {
            logic last;
        } hdr;
        logic [15:0] payload;
    },
    parameter int  IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
);
    logic [NumInputs-1:0]  valid_i;
    logic [NumInputs-1:0]  ready_o;
    flit_t [NumInputs-1:0] data_i;
    logic                  valid_o;
    logic                  ready_i;
    flit_t                 data_o;
    logic [IdxWidth-1:0]   grant_idx_o;
    logic                  locked_o;

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, grant_idx_o, locked_o
    );

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, grant_idx_o, locked_o
    );
endinterface

// File: rtl/floo_wormhole_arbiter.sv
// Output-port round-robin arbiter with wormhole lock: the grant is held for a whole
// packet and frozen while the output link stalls; the datapath is purely combinational.
module floo_wormhole_arbiter #(
    parameter int  NumInputs   = 5,
    parameter type flit_t      = struct packed {
        struct packed {
            logic last;
        } hdr;
        logic [15:0] payload;
    },
    parameter bit  LockRouting = 1'b1,
    parameter int  IdxWidth    = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input logic                    clk_i,
    input logic                    rst_i,
    floo_wormhole_arbiter_if.slave bus
);

    // HOLD freezes the grant under backpressure; LOCKED holds it across a packet.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_LOCKED
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IdxWidth-1:0] r_idx;
    logic [IdxWidth-1:0] w_idx_next;
    logic [IdxWidth-1:0] r_rr_ptr;
    logic [IdxWidth-1:0] w_rr_ptr_next;

    logic [IdxWidth-1:0] w_cand [NumInputs];
    logic [IdxWidth-1:0] w_rr_grant;
    logic [IdxWidth-1:0] w_grant;
    logic [IdxWidth-1:0] w_grant_inc;
    flit_t               w_grant_flit;
    logic                w_valid;
    logic                w_fire;

    genvar gi;

    // w_cand[k] is the input examined k-th, starting from the round-robin pointer.
    generate
        for (gi = 0; gi < NumInputs; gi++) begin : g_rot
            logic [IdxWidth:0] w_sum;
            assign w_sum = {1'b0, r_rr_ptr} + (IdxWidth+1)'(gi);
            assign w_cand[gi] = (w_sum >= (IdxWidth+1)'(NumInputs))
                              ? IdxWidth'(w_sum - (IdxWidth+1)'(NumInputs))
                              : IdxWidth'(w_sum);
        end
    endgenerate

    // Scan from the far end so the candidate closest to the pointer wins.
    always_comb begin
        w_rr_grant = r_rr_ptr;
        for (int k = NumInputs - 1; k >= 0; k--) begin
            if (bus.valid_i[w_cand[k]]) begin
                w_rr_grant = w_cand[k];
            end
        end
    end

    assign w_grant      = (r_state == ST_IDLE) ? w_rr_grant : r_idx;
    assign w_grant_flit = bus.data_i[w_grant];
    assign w_valid      = bus.valid_i[w_grant];
    assign w_fire       = w_valid && bus.ready_i;
    assign w_grant_inc  = ({1'b0, w_grant} == (IdxWidth+1)'(NumInputs - 1))
                        ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_rr_ptr <= w_rr_ptr_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_rr_ptr_next = r_rr_ptr;
        if (w_fire) begin
            if (LockRouting && !w_grant_flit.hdr.last) begin
                w_state_next = ST_LOCKED;
                w_idx_next   = w_grant;
            end else begin
                w_state_next  = ST_IDLE;
                w_rr_ptr_next = w_grant_inc;
            end
        end else if (w_valid && !bus.ready_i && (r_state != ST_LOCKED)) begin
            w_state_next = ST_HOLD;
            w_idx_next   = w_grant;
        end
    end

    generate
        for (gi = 0; gi < NumInputs; gi++) begin : g_ready
            assign bus.ready_o[gi] = (w_grant == IdxWidth'(gi)) && bus.ready_i;
        end
    endgenerate

    assign bus.valid_o     = w_valid;
    assign bus.data_o      = w_grant_flit;
    assign bus.grant_idx_o = w_grant;
    assign bus.locked_o    = (r_state == ST_LOCKED);

`ifndef SYNTHESIS
    a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.valid_o && !bus.ready_i) |=> $stable(bus.data_o));
`endif

endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// Scenario bench for floo_wormhole_arbiter: per-input source queues feed the DUT and
// a scoreboard of expected (grant, flit) pairs is checked on every output transfer.
module tb_floo_wormhole_arbiter;
    localparam int N = 5;

    typedef struct packed {
        logic last;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [15:0] payload;
    } flit_t;

    typedef struct packed {
        logic [2:0] idx;
        flit_t      flit;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    floo_wormhole_arbiter_if #(.NumInputs(N), .flit_t(flit_t)) bus ();

    floo_wormhole_arbiter #(
        .NumInputs  (N),
        .flit_t     (flit_t),
        .LockRouting(1'b1)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int           checks   = 0;
    int           failures = 0;
    flit_t        src_q [N][$];
    exp_t         exp_q [$];
    exp_t         mon_e;
    logic [N-1:0] gate = '0;
    logic [N-1:0] fire = '0;

    function automatic flit_t mk(logic last, logic [15:0] payload);
        flit_t f;
        f.hdr.last = last;
        f.payload  = payload;
        return f;
    endfunction

    function automatic flit_t idle_flit(int i);
        return mk(1'b0, 16'hE000 + 16'(i));
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.valid_i[i] = (src_q[i].size() != 0) && !gate[i];
            bus.data_i[i]  = (src_q[i].size() != 0) ? src_q[i][0] : idle_flit(i);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic enqueue(int i, int n, logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            src_q[i].push_back(mk(k == n - 1, base + 16'(k)));
        end
    endtask

    task automatic expect_pkt(int i, int n, logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{idx: 3'(i), flit: mk(k == n - 1, base + 16'(k))});
        end
    endtask

    task automatic wait_drain(int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Upstream model: pop the head flit of every input that handshook in the last cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            fire = rst_i ? '0 : (bus.valid_i & bus.ready_o);
            @(posedge clk_i);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            end
            drive();
        end
    end

    // Scoreboard: every output transfer must match the next expected (grant, flit).
    always @(negedge clk_i) begin
        if (!rst_i && bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_transfer: got grant=%0d data=%h, required no transfer",
                         bus.grant_idx_o, bus.data_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.grant_idx_o !== mon_e.idx || bus.data_o !== mon_e.flit) begin
                    failures++;
                    $display("FAIL transfer: got grant=%0d data=%h, required grant=%0d data=%h",
                             bus.grant_idx_o, bus.data_o, mon_e.idx, mon_e.flit);
                end
            end
        end
    end

    task automatic test_reset();
        rst_i        = 1'b1;
        bus.ready_i  = 1'b0;
        gate         = '0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        step();
        step();
        rst_i = 1'b0;
        step();
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b, required 0", bus.valid_o);
        end
        checks++;
        if (bus.ready_o !== 5'b00000) begin
            failures++; $display("FAIL reset_ready: got %b, required 00000", bus.ready_o);
        end
        checks++;
        if (bus.locked_o !== 1'b0) begin
            failures++; $display("FAIL reset_locked: got %b, required 0", bus.locked_o);
        end
        checks++;
        if (bus.grant_idx_o !== 3'd0) begin
            failures++; $display("FAIL reset_grant: got %0d, required 0", bus.grant_idx_o);
        end
        checks++;
        if (bus.data_o !== idle_flit(0)) begin
            failures++; $display("FAIL reset_data: got %h, required %h", bus.data_o, idle_flit(0));
        end
    endtask

    task automatic test_single_flit();
        bit ok;
        bus.ready_i = 1'b1;
        enqueue(2, 1, 16'h0200);
        enqueue(4, 1, 16'h0400);
        expect_pkt(2, 1, 16'h0200);
        expect_pkt(4, 1, 16'h0400);
        drive();
        #1;
        checks++;
        if (bus.grant_idx_o !== 3'd2 || bus.ready_o !== 5'b00100) begin
            failures++;
            $display("FAIL single_first: got grant=%0d ready=%b, required grant=2 ready=00100",
                     bus.grant_idx_o, bus.ready_o);
        end
        step();
        checks++;
        if (bus.grant_idx_o !== 3'd4 || bus.ready_o !== 5'b10000) begin
            failures++;
            $display("FAIL single_second: got grant=%0d ready=%b, required grant=4 ready=10000",
                     bus.grant_idx_o, bus.ready_o);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL single_drain: got %0d pending, required 0", exp_q.size());
        end
        // Pointer must be back at 0: input 0 beats input 4.
        enqueue(0, 1, 16'h0010);
        enqueue(4, 1, 16'h0410);
        expect_pkt(0, 1, 16'h0010);
        expect_pkt(4, 1, 16'h0410);
        drive();
        #1;
        checks++;
        if (bus.grant_idx_o !== 3'd0) begin
            failures++; $display("FAIL single_rr_zero: got grant=%0d, required 0", bus.grant_idx_o);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL single_drain2: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_wormhole();
        bit ok;
        bus.ready_i = 1'b1;
        enqueue(1, 3, 16'h1100);
        enqueue(3, 1, 16'h3300);
        expect_pkt(1, 3, 16'h1100);
        expect_pkt(3, 1, 16'h3300);
        drive();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.grant_idx_o !== 3'd1 || bus.ready_o !== 5'b00010 || bus.locked_o !== (k != 0)) begin
                failures++;
                $display("FAIL wormhole_flit%0d: got grant=%0d ready=%b locked=%b, required grant=1 ready=00010 locked=%0d",
                         k, bus.grant_idx_o, bus.ready_o, bus.locked_o, (k != 0));
            end
            step();
        end
        checks++;
        if (bus.locked_o !== 1'b0 || bus.grant_idx_o !== 3'd3) begin
            failures++;
            $display("FAIL wormhole_release: got locked=%b grant=%0d, required locked=0 grant=3",
                     bus.locked_o, bus.grant_idx_o);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL wormhole_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit    ok;
        flit_t held;
        bus.ready_i = 1'b1;
        enqueue(0, 1, 16'h0020);
        expect_pkt(0, 1, 16'h0020);
        drive();
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL bp_prep_drain: got %0d pending, required 0", exp_q.size());
        end
        // Pointer is now 1, so without the hold a later request from input 2 would win.
        held        = mk(1'b1, 16'h0030);
        bus.ready_i = 1'b0;
        enqueue(0, 1, 16'h0030);
        expect_pkt(0, 1, 16'h0030);
        drive();
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.grant_idx_o !== 3'd0 || bus.valid_o !== 1'b1 || bus.data_o !== held || bus.ready_o !== 5'b00000) begin
                failures++;
                $display("FAIL bp_stall%0d: got grant=%0d valid=%b data=%h ready=%b, required grant=0 valid=1 data=%h ready=00000",
                         k, bus.grant_idx_o, bus.valid_o, bus.data_o, bus.ready_o, held);
            end
            step();
        end
        enqueue(2, 1, 16'h0230);
        expect_pkt(2, 1, 16'h0230);
        drive();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.grant_idx_o !== 3'd0 || bus.data_o !== held) begin
                failures++;
                $display("FAIL bp_hold%0d: got grant=%0d data=%h, required grant=0 data=%h",
                         k, bus.grant_idx_o, bus.data_o, held);
            end
            step();
        end
        bus.ready_i = 1'b1;
        #1;
        checks++;
        if (bus.grant_idx_o !== 3'd0 || bus.ready_o !== 5'b00001) begin
            failures++;
            $display("FAIL bp_release: got grant=%0d ready=%b, required grant=0 ready=00001",
                     bus.grant_idx_o, bus.ready_o);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        bus.ready_i = 1'b1;
        enqueue(3, 1, 16'h3010);
        expect_pkt(3, 1, 16'h3010);
        drive();
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL wrap_prep_drain: got %0d pending, required 0", exp_q.size());
        end
        for (int i = 0; i < N; i++) enqueue(i, 1, 16'h5000 + 16'(i));
        for (int k = 0; k < N; k++) expect_pkt((4 + k) % N, 1, 16'h5000 + 16'((4 + k) % N));
        drive();
        #1;
        checks++;
        if (bus.grant_idx_o !== 3'd4) begin
            failures++; $display("FAIL wrap_first: got grant=%0d, required 4", bus.grant_idx_o);
        end
        wait_drain(30, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL wrap_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_bubble();
        bit ok;
        bus.ready_i = 1'b1;
        enqueue(2, 3, 16'h2200);
        expect_pkt(2, 3, 16'h2200);
        drive();
        #1;
        checks++;
        if (bus.grant_idx_o !== 3'd2) begin
            failures++; $display("FAIL bubble_start: got grant=%0d, required 2", bus.grant_idx_o);
        end
        step();
        gate[2] = 1'b1;
        enqueue(0, 1, 16'h0040);
        enqueue(4, 1, 16'h4040);
        expect_pkt(4, 1, 16'h4040);
        expect_pkt(0, 1, 16'h0040);
        drive();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.valid_o !== 1'b0 || bus.locked_o !== 1'b1 || bus.grant_idx_o !== 3'd2 || bus.ready_o !== 5'b00100) begin
                failures++;
                $display("FAIL bubble_gap%0d: got valid=%b locked=%b grant=%0d ready=%b, required valid=0 locked=1 grant=2 ready=00100",
                         k, bus.valid_o, bus.locked_o, bus.grant_idx_o, bus.ready_o);
            end
            step();
        end
        gate[2] = 1'b0;
        drive();
        #1;
        checks++;
        if (bus.grant_idx_o !== 3'd2 || bus.valid_o !== 1'b1) begin
            failures++;
            $display("FAIL bubble_resume: got grant=%0d valid=%b, required grant=2 valid=1",
                     bus.grant_idx_o, bus.valid_o);
        end
        wait_drain(30, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL bubble_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midpacket();
        bit ok;
        bus.ready_i = 1'b1;
        enqueue(3, 4, 16'h3300);
        exp_q.push_back('{idx: 3'd3, flit: mk(1'b0, 16'h3300)});
        drive();
        #1;
        checks++;
        if (bus.grant_idx_o !== 3'd3) begin
            failures++; $display("FAIL rstmid_grant: got grant=%0d, required 3", bus.grant_idx_o);
        end
        step();
        checks++;
        if (bus.locked_o !== 1'b1) begin
            failures++; $display("FAIL rstmid_locked: got %b, required 1", bus.locked_o);
        end
        rst_i = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive();
        step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (bus.locked_o !== 1'b0 || bus.valid_o !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_cleared: got locked=%b valid=%b pending=%0d, required locked=0 valid=0 pending=0",
                     bus.locked_o, bus.valid_o, exp_q.size());
        end
        enqueue(0, 1, 16'h0050);
        enqueue(3, 1, 16'h3350);
        expect_pkt(0, 1, 16'h0050);
        expect_pkt(3, 1, 16'h3350);
        drive();
        #1;
        checks++;
        if (bus.grant_idx_o !== 3'd0) begin
            failures++; $display("FAIL rstmid_restart: got grant=%0d, required 0", bus.grant_idx_o);
        end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL rstmid_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.ready_i = 1'b0;
        drive();
        test_reset();
        test_single_flit();
        test_wormhole();
        test_backpressure();
        test_wrap();
        test_bubble();
        test_reset_midpacket();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
